// File: rtl/bus_pkg.sv
// Shared constants for the CPU bus multiplexer: source index map and default sizes.
package bus_pkg;

  localparam int BUS_WIDTH   = 32;
  localparam int BUS_NUM_SRC = 24;

  // Source index map; R0..R15 occupy 0..15 directly.
  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_prio_encoder.sv
// Lowest-index-wins priority encoder over the bus drive enables, with
// any-active and more-than-one-active flags.
module bus_prio_encoder
  import bus_pkg::*;
#(
  parameter  int NUM_SRC = BUS_NUM_SRC,
  localparam int SRC_W   = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] en_i,
  output logic [SRC_W-1:0]   win_o,
  output logic               any_en_o,
  output logic               multi_en_o
);

  always_comb begin
    win_o = '0;
    // Walk downward so the lowest set index is the last assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (en_i[i]) win_o = SRC_W'(i);
    end
  end

  assign any_en_o   = |en_i;
  assign multi_en_o = |(en_i & (en_i - NUM_SRC'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Registered CPU bus multiplexer with multi-driver conflict flags.
// Define BUS_CONFLICT_CNT_EN to add the saturating conflict_count port.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter  int WIDTH   = BUS_WIDTH,
  parameter  int NUM_SRC = BUS_NUM_SRC,
`ifdef BUS_CONFLICT_CNT_EN
  parameter  int CNT_W   = 8,
`endif
  localparam int SRC_W   = src_w(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic                     hold,
  input  logic                     clr_conflict,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [SRC_W-1:0]         bus_src,
  output logic                     conflict,
`ifdef BUS_CONFLICT_CNT_EN
  output logic [CNT_W-1:0]         conflict_count,
`endif
  output logic                     conflict_sticky
);

  logic [NUM_SRC-1:0][WIDTH-1:0] src_arr;
  logic [SRC_W-1:0]              win;
  logic                          any_en, multi_en, conf_ev;

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic [SRC_W-1:0] bus_src_q, bus_src_d;
  logic             bus_valid_q, bus_valid_d;
  logic             conflict_q, conflict_d;
  logic             sticky_q, sticky_d;

  assign src_arr = src_data;

  bus_prio_encoder #(.NUM_SRC(NUM_SRC)) u_enc (
    .en_i       (src_en),
    .win_o      (win),
    .any_en_o   (any_en),
    .multi_en_o (multi_en)
  );

  assign conf_ev = !hold && multi_en;

  always_comb begin
    bus_out_d   = bus_out_q;
    bus_src_d   = bus_src_q;
    bus_valid_d = bus_valid_q;
    conflict_d  = conflict_q;
    if (!hold) begin
      bus_valid_d = any_en;
      conflict_d  = multi_en;
      if (any_en) begin
        bus_out_d = src_arr[win];
        bus_src_d = win;
      end
    end
    // A conflict in the clearing cycle survives the clear.
    sticky_d = (sticky_q && !clr_conflict) || conf_ev;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_out_q   <= '0;
      bus_src_q   <= '0;
      bus_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_src_q   <= bus_src_d;
      bus_valid_q <= bus_valid_d;
      conflict_q  <= conflict_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_conflict)             cnt_d = conf_ev ? CNT_W'(1) : '0;
    else if (conf_ev && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_count = cnt_q;
`endif

  assign bus_out         = bus_out_q;
  assign bus_src         = bus_src_q;
  assign bus_valid       = bus_valid_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg; checks the counter too when BUS_CONFLICT_CNT_EN is defined.
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 24;
  localparam int SRC_W   = 5;
  localparam int CNT_W   = 2;

  logic                          clk = 1'b0;
  logic                          clr_n;
  logic [NUM_SRC-1:0][WIDTH-1:0] srcs;
  logic [NUM_SRC-1:0]            src_en;
  logic                          hold, clr_conflict;
  logic [WIDTH-1:0]              bus_out;
  logic                          bus_valid, conflict, conflict_sticky;
  logic [SRC_W-1:0]              bus_src;
`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0]              conflict_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_mux_reg #(
    .WIDTH   (WIDTH),
`ifdef BUS_CONFLICT_CNT_EN
    .CNT_W   (CNT_W),
`endif
    .NUM_SRC (NUM_SRC)
  ) dut (
    .clk             (clk),
    .clr_n           (clr_n),
    .src_data        (srcs),
    .src_en          (src_en),
    .hold            (hold),
    .clr_conflict    (clr_conflict),
    .bus_out         (bus_out),
    .bus_valid       (bus_valid),
    .bus_src         (bus_src),
    .conflict        (conflict),
`ifdef BUS_CONFLICT_CNT_EN
    .conflict_count  (conflict_count),
`endif
    .conflict_sticky (conflict_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input int src,
                         input logic v, input logic c, input logic s);
    chk({tag, ".bus_out"},   64'(bus_out),         64'(d));
    chk({tag, ".bus_src"},   64'(bus_src),         64'(src));
    chk({tag, ".bus_valid"}, 64'(bus_valid),       64'(v));
    chk({tag, ".conflict"},  64'(conflict),        64'(c));
    chk({tag, ".sticky"},    64'(conflict_sticky), 64'(s));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef BUS_CONFLICT_CNT_EN
    chk({tag, ".count"}, 64'(conflict_count), 64'(exp));
`endif
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) srcs[i] = 32'h1000_0000 + 32'(i);
    srcs[3]       = 32'hAAAA_5555;
    srcs[7]       = 32'h1234_5678;
    srcs[SRC_PC]  = 32'h0000_0040;
    srcs[SRC_MDR] = 32'hDEAD_BEEF;
    src_en = '0; hold = 1'b0; clr_conflict = 1'b0;

    clr_n = 1'b0;
    #2;
    chk_out("reset", 32'h0, 0, 1'b0, 1'b0, 1'b0);
    chk_cnt("reset", 0);
    src_en = NUM_SRC'(1) << SRC_PC;
    #10 clr_n = 1'b1;

    step();
    chk_out("pc_drive", 32'h40, SRC_PC, 1'b1, 1'b0, 1'b0);

    src_en = '0;
    step();
    chk_out("idle_hold", 32'h40, SRC_PC, 1'b0, 1'b0, 1'b0);

    src_en = (NUM_SRC'(1) << 3) | (NUM_SRC'(1) << SRC_MDR);
    step();
    chk_out("r3_mdr_conf", 32'hAAAA_5555, 3, 1'b1, 1'b1, 1'b1);
    chk_cnt("r3_mdr_conf", 1);
    src_en = '0;
    step();
    chk_out("conf_pulse_end", 32'hAAAA_5555, 3, 1'b0, 1'b0, 1'b1);

    hold = 1'b1;
    src_en = NUM_SRC'(1) << 7;
    step();
    chk_out("hold_r7", 32'hAAAA_5555, 3, 1'b0, 1'b0, 1'b1);
    src_en = (NUM_SRC'(1) << 7) | (NUM_SRC'(1) << 9);
    step();
    chk_out("hold_conf_ign", 32'hAAAA_5555, 3, 1'b0, 1'b0, 1'b1);
    chk_cnt("hold_conf_ign", 1);
    hold = 1'b0;
    src_en = NUM_SRC'(1) << 7;
    step();
    chk_out("release_r7", 32'h1234_5678, 7, 1'b1, 1'b0, 1'b1);

    src_en = NUM_SRC'(1) << SRC_CSIGN;
    clr_conflict = 1'b1;
    step();
    chk_out("top_src_clr", 32'h1000_0017, SRC_CSIGN, 1'b1, 1'b0, 1'b0);
    chk_cnt("top_src_clr", 0);
    clr_conflict = 1'b0;

    src_en = (NUM_SRC'(1) << SRC_R0) | (NUM_SRC'(1) << SRC_CSIGN);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_cnt($sformatf("sat%0d", k), (k > 3) ? 3 : k);
    end
    chk_out("sat_end", 32'h1000_0000, SRC_R0, 1'b1, 1'b1, 1'b1);

    clr_conflict = 1'b1;
    step();
    chk_out("clr_with_conf", 32'h1000_0000, SRC_R0, 1'b1, 1'b1, 1'b1);
    chk_cnt("clr_with_conf", 1);

    hold = 1'b1;
    step();
    chk_out("clr_in_hold", 32'h1000_0000, SRC_R0, 1'b1, 1'b1, 1'b0);
    chk_cnt("clr_in_hold", 0);
    hold = 1'b0; clr_conflict = 1'b0;

    src_en = NUM_SRC'(1) << SRC_INPORT;
    step();
    chk_out("inport", 32'h1000_0016, SRC_INPORT, 1'b1, 1'b0, 1'b0);
    src_en = (NUM_SRC'(1) << SRC_HI) | (NUM_SRC'(1) << SRC_LO);
    step();
    chk_out("hi_lo_conf", 32'h1000_0010, SRC_HI, 1'b1, 1'b1, 1'b1);
    #3 clr_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 0, 1'b0, 1'b0, 1'b0);
    chk_cnt("async_rst", 0);
    src_en = NUM_SRC'(1) << 1;
    #2 clr_n = 1'b1;
    step();
    chk_out("post_rst", 32'h1000_0001, 1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
